// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the param_dcache slice:
//   - dcache_state_e : controller FSM encodings (IDLE, FILL, WRITE)
//   - calc_offset_w / calc_index_w / calc_tag_w : address-split width helpers
//   - CNT_W : statistics counter width
// No ports (package).
// ---------------------------------------------------------------------------
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } dcache_state_e;

   localparam int CNT_W = 32;

   // Word-offset field width: log2 of words per line.
   function automatic int calc_offset_w(input int words);
      return $clog2(words);
   endfunction

   // Index field width: log2 of the number of lines.
   function automatic int calc_index_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag field width: whatever address bits remain above offset and index.
   function automatic int calc_tag_w(input int addr_w, input int words, input int lines);
      return addr_w - $clog2(words) - $clog2(lines);
   endfunction

endpackage

// File: rtl/param_dcache_if.sv
// ---------------------------------------------------------------------------
// param_dcache_if
// Bundles the CPU-side and memory-side signals of param_dcache.
//   CPU side   : rd_req, wr_req, adr, wdata (to cache); rdata, ready, hit (from cache)
//   Memory side: mem_rd_req, mem_wr_req, mem_adr, mem_wdata (from cache);
//                mem_line, mem_ack (to cache)
//   Statistics : hit_cnt, miss_cnt (from cache)
// Modports:
//   slave  - the cache itself
//   master - the environment (CPU + memory model)
// ---------------------------------------------------------------------------
interface param_dcache_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int WORDS  = 4
);
   logic                      rd_req;
   logic                      wr_req;
   logic [ADDR_W-1:0]         adr;
   logic [DATA_W-1:0]         wdata;
   logic [DATA_W-1:0]         rdata;
   logic                      ready;
   logic                      hit;
   logic                      mem_rd_req;
   logic                      mem_wr_req;
   logic [ADDR_W-1:0]         mem_adr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W*WORDS-1:0]   mem_line;
   logic                      mem_ack;
   logic [31:0]               hit_cnt;
   logic [31:0]               miss_cnt;

   modport slave (
      input  rd_req, wr_req, adr, wdata, mem_line, mem_ack,
      output rdata, ready, hit, mem_rd_req, mem_wr_req, mem_adr, mem_wdata,
             hit_cnt, miss_cnt
   );

   modport master (
      output rd_req, wr_req, adr, wdata, mem_line, mem_ack,
      input  rdata, ready, hit, mem_rd_req, mem_wr_req, mem_adr, mem_wdata,
             hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dcache_stats.sv
// ---------------------------------------------------------------------------
// dcache_stats
// Saturating hit / miss event counters for param_dcache.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_hit_inc    : one-cycle pulse per read hit served
//   i_miss_inc   : one-cycle pulse per line fill started
//   o_hit_cnt    : hit count, saturates at all-ones
//   o_miss_cnt   : miss count, saturates at all-ones
// Only instantiated when DCACHE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module dcache_stats
   import dcache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_hit_inc,
   input  logic             i_miss_inc,
   output logic [CNT_W-1:0] o_hit_cnt,
   output logic [CNT_W-1:0] o_miss_cnt
);
   logic [CNT_W-1:0] r_hit_cnt;
   logic [CNT_W-1:0] r_miss_cnt;

   // Hit/miss counters, each holding at the maximum instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (i_hit_inc && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (i_miss_inc && (r_miss_cnt != {CNT_W{1'b1}})) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign o_hit_cnt  = r_hit_cnt;
   assign o_miss_cnt = r_miss_cnt;
endmodule

// File: rtl/param_dcache.sv
// ---------------------------------------------------------------------------
// param_dcache
// Direct-mapped, write-through, no-write-allocate data cache.
// Parameters: ADDR_W (word address width), DATA_W (word width),
//             WORDS (words per line, power of 2, >=2), LINES (power of 2).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : param_dcache_if.slave (CPU request/response, memory
//            request/ack, hit indication, statistics counters)
// Address split: {tag, index, offset}, offset selects the word in a line.
// Optional feature: define DCACHE_STATS_EN to build the hit/miss counters
// (dcache_stats); otherwise hit_cnt and miss_cnt are constant zero.
// ---------------------------------------------------------------------------
module param_dcache
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32,
   parameter int WORDS  = 4,
   parameter int LINES  = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   param_dcache_if.slave  bus
);
   localparam int OFFSET_W = calc_offset_w(WORDS);
   localparam int INDEX_W  = calc_index_w(LINES);
   localparam int TAG_W    = calc_tag_w(ADDR_W, WORDS, LINES);

   typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

   // Storage: line data and tags carry no reset; only valid bits are cleared.
   line_t               r_line_mem [LINES];
   logic [TAG_W-1:0]    r_tag_mem  [LINES];
   logic [LINES-1:0]    r_valid;

   dcache_state_e       r_state;
   logic [ADDR_W-1:0]   r_adr;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_ready;
   logic                r_mem_rd_req;
   logic                r_mem_wr_req;
   logic [ADDR_W-1:0]   r_mem_adr;
   logic [DATA_W-1:0]   r_mem_wdata;

   // Fields of the live CPU address.
   logic [TAG_W-1:0]    w_tag;
   logic [INDEX_W-1:0]  w_idx;
   logic [OFFSET_W-1:0] w_off;
   // Fields of the address latched for the in-flight FILL/WRITE.
   logic [TAG_W-1:0]    w_r_tag;
   logic [INDEX_W-1:0]  w_r_idx;
   logic [OFFSET_W-1:0] w_r_off;

   line_t               w_mem_words;
   logic                w_hit;
   logic                w_fill_we;
   logic                w_wr_we;

   assign w_tag   = bus.adr[ADDR_W-1 -: TAG_W];
   assign w_idx   = bus.adr[OFFSET_W +: INDEX_W];
   assign w_off   = bus.adr[OFFSET_W-1:0];
   assign w_r_tag = r_adr[ADDR_W-1 -: TAG_W];
   assign w_r_idx = r_adr[OFFSET_W +: INDEX_W];
   assign w_r_off = r_adr[OFFSET_W-1:0];

   // Word k of the incoming line sits at bits [DATA_W*(k+1)-1 : DATA_W*k].
   assign w_mem_words = bus.mem_line;

   assign w_hit = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag);

   // Line install on fill completion; a write only touches the array when the
   // latched address still hits at ack time (no-write-allocate).
   assign w_fill_we = (r_state == FILL) && bus.mem_ack;
   assign w_wr_we   = (r_state == WRITE) && bus.mem_ack &&
                      r_valid[w_r_idx] && (r_tag_mem[w_r_idx] == w_r_tag);

   // Data and tag array updates.
   always_ff @(posedge clk) begin
      if (w_fill_we) begin
         r_line_mem[w_r_idx] <= w_mem_words;
         r_tag_mem[w_r_idx]  <= w_r_tag;
      end else if (w_wr_we) begin
         r_line_mem[w_r_idx][w_r_off] <= r_mem_wdata;
      end
   end

   // Controller FSM with registered CPU and memory outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_adr        <= '0;
         r_rdata      <= '0;
         r_ready      <= 1'b0;
         r_mem_rd_req <= 1'b0;
         r_mem_wr_req <= 1'b0;
         r_mem_adr    <= '0;
         r_mem_wdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_ready) begin
                  // The request that earned this pulse may still be held;
                  // skip one cycle so it is not served twice.
                  r_ready <= 1'b0;
               end else if (bus.wr_req) begin
                  r_state      <= WRITE;
                  r_adr        <= bus.adr;
                  r_mem_wr_req <= 1'b1;
                  r_mem_adr    <= bus.adr;
                  r_mem_wdata  <= bus.wdata;
               end else if (bus.rd_req) begin
                  if (w_hit) begin
                     r_rdata <= r_line_mem[w_idx][w_off];
                     r_ready <= 1'b1;
                  end else begin
                     r_state      <= FILL;
                     r_adr        <= bus.adr;
                     r_mem_rd_req <= 1'b1;
                     r_mem_adr    <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
                  end
               end
            end
            FILL: begin
               if (bus.mem_ack) begin
                  r_valid[w_r_idx] <= 1'b1;
                  r_rdata          <= w_mem_words[w_r_off];
                  r_ready          <= 1'b1;
                  r_mem_rd_req     <= 1'b0;
                  r_state          <= IDLE;
               end
            end
            WRITE: begin
               if (bus.mem_ack) begin
                  r_ready      <= 1'b1;
                  r_mem_wr_req <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_ready      <= 1'b0;
               r_mem_rd_req <= 1'b0;
               r_mem_wr_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.hit        = w_hit;
   assign bus.rdata      = r_rdata;
   assign bus.ready      = r_ready;
   assign bus.mem_rd_req = r_mem_rd_req;
   assign bus.mem_wr_req = r_mem_wr_req;
   assign bus.mem_adr    = r_mem_adr;
   assign bus.mem_wdata  = r_mem_wdata;

`ifdef DCACHE_STATS_EN
   logic w_hit_inc;
   logic w_miss_inc;

   // Count only requests actually accepted in IDLE (not the skip cycle).
   assign w_hit_inc  = (r_state == IDLE) && !r_ready && !bus.wr_req &&
                       bus.rd_req && w_hit;
   assign w_miss_inc = (r_state == IDLE) && !r_ready && !bus.wr_req &&
                       bus.rd_req && !w_hit;

   dcache_stats u_stats (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_hit_inc  (w_hit_inc),
      .i_miss_inc (w_miss_inc),
      .o_hit_cnt  (bus.hit_cnt),
      .o_miss_cnt (bus.miss_cnt)
   );
`else
   assign bus.hit_cnt  = 32'd0;
   assign bus.miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_param_dcache.sv
// ---------------------------------------------------------------------------
// tb_param_dcache
// Scoreboard bench for param_dcache: stimulus tasks push expected CPU
// responses and memory requests into queues; independent monitors pop and
// compare whenever the DUT pulses ready or raises a memory request.
// ---------------------------------------------------------------------------
module tb_param_dcache;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;
   localparam int WORDS  = 4;
   localparam int LINES  = 1024;

`ifdef DCACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      bit                is_wr;
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] wdata;
   } mem_exp_t;

   logic clk;
   logic rst_n;

   int vectors;
   int miscompares;

   logic [DATA_W-1:0] rsp_q [$];
   mem_exp_t          mem_q [$];

   param_dcache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) bus ();

   param_dcache #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .WORDS  (WORDS),
      .LINES  (LINES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] cnt_exp(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   // Response monitor: every ready pulse must match the next expected rdata.
   always @(negedge clk) begin
      if (bus.ready === 1'b1) begin
         if (rsp_q.size() == 0) begin
            chk("unexpected_ready", 64'd1, 64'd0);
         end else begin
            logic [DATA_W-1:0] e;
            e = rsp_q.pop_front();
            chk("rdata", 64'(bus.rdata), 64'(e));
         end
      end
   end

   // Memory monitor: each rising request must match the next expected one.
   bit prev_rd = 1'b0;
   bit prev_wr = 1'b0;
   always @(negedge clk) begin
      if ((bus.mem_rd_req === 1'b1) && (bus.mem_wr_req === 1'b1)) begin
         chk("mem_req_exclusive", 64'd1, 64'd0);
      end
      if (((bus.mem_rd_req === 1'b1) && !prev_rd) || ((bus.mem_wr_req === 1'b1) && !prev_wr)) begin
         if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", 64'd1, 64'd0);
         end else begin
            mem_exp_t m;
            m = mem_q.pop_front();
            chk("mem_is_wr", 64'(bus.mem_wr_req), 64'(m.is_wr));
            chk("mem_adr", 64'(bus.mem_adr), 64'(m.adr));
            if (m.is_wr) begin
               chk("mem_wdata", 64'(bus.mem_wdata), 64'(m.wdata));
            end
         end
      end
      prev_rd = (bus.mem_rd_req === 1'b1);
      prev_wr = (bus.mem_wr_req === 1'b1);
   end

   // Wait for ready, acknowledging one memory request with the given line.
   task automatic wait_ready(input string name, input logic [DATA_W*WORDS-1:0] line);
      bit acked;
      bit seen;
      acked = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.ready === 1'b1) begin
            seen = 1'b1;
         end else if (!acked && ((bus.mem_rd_req === 1'b1) || (bus.mem_wr_req === 1'b1))) begin
            bus.mem_line = line;
            bus.mem_ack  = 1'b1;
            acked        = 1'b1;
         end else begin
            bus.mem_ack = 1'b0;
         end
      end
      bus.mem_ack = 1'b0;
      if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp,
                           input bit miss, input logic [DATA_W*WORDS-1:0] line);
      mem_exp_t m;
      @(negedge clk);
      bus.adr = a;
      #1;
      chk("hit_before_read", 64'(bus.hit), 64'(!miss));
      rsp_q.push_back(exp);
      if (miss) begin
         m.is_wr = 1'b0;
         m.adr   = a & ~15'd3;
         m.wdata = 32'd0;
         mem_q.push_back(m);
      end
      bus.rd_req = 1'b1;
      wait_ready("read", line);
      bus.rd_req = 1'b0;
   endtask

   task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                            input bit exp_hit, input logic [DATA_W-1:0] held);
      mem_exp_t m;
      @(negedge clk);
      bus.adr   = a;
      bus.wdata = wd;
      #1;
      chk("hit_before_write", 64'(bus.hit), 64'(exp_hit));
      m.is_wr = 1'b1;
      m.adr   = a;
      m.wdata = wd;
      mem_q.push_back(m);
      rsp_q.push_back(held);
      bus.wr_req = 1'b1;
      wait_ready("write", 128'd0);
      bus.wr_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DATA_W*WORDS-1:0] line_a;
      logic [DATA_W*WORDS-1:0] line_b;
      mem_exp_t m;
      bit got;

      vectors     = 0;
      miscompares = 0;
      line_a = {32'h44, 32'h33, 32'h22, 32'h11};
      line_b = {32'h5004, 32'h5003, 32'h5002, 32'h5001};

      rst_n        = 1'b0;
      bus.rd_req   = 1'b0;
      bus.wr_req   = 1'b0;
      bus.adr      = 15'd0;
      bus.wdata    = 32'd0;
      bus.mem_line = 128'd0;
      bus.mem_ack  = 1'b0;

      // Reset state.
      #23;
      chk("rst_rdata", 64'(bus.rdata), 64'd0);
      chk("rst_ready", 64'(bus.ready), 64'd0);
      chk("rst_mem_rd_req", 64'(bus.mem_rd_req), 64'd0);
      chk("rst_mem_wr_req", 64'(bus.mem_wr_req), 64'd0);
      chk("rst_mem_adr", 64'(bus.mem_adr), 64'd0);
      chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("rst_hit_cnt", 64'(bus.hit_cnt), 64'd0);
      chk("rst_miss_cnt", 64'(bus.miss_cnt), 64'd0);
      chk("rst_hit", 64'(bus.hit), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Read miss at 10 fills line at 8, returns word 2.
      cpu_read(15'd10, 32'h33, 1'b1, line_a);
      chk("miss_cnt_1", 64'(bus.miss_cnt), 64'(cnt_exp(1)));
      chk("hit_cnt_0", 64'(bus.hit_cnt), 64'(cnt_exp(0)));

      // Read hit at 9.
      cpu_read(15'd9, 32'h22, 1'b0, 128'd0);
      chk("hit_cnt_1", 64'(bus.hit_cnt), 64'(cnt_exp(1)));

      // Write hit at 9, rdata held at 0x22, then re-read from cache.
      cpu_write(15'd9, 32'hAA, 1'b1, 32'h22);
      cpu_read(15'd9, 32'hAA, 1'b0, 128'd0);

      // Write miss at 0x1009: memory only, cache untouched, no allocate.
      cpu_write(15'h1009, 32'hBB, 1'b0, 32'hAA);
      @(negedge clk);
      bus.adr = 15'h1009;
      #1;
      chk("no_write_allocate", 64'(bus.hit), 64'd0);
      cpu_read(15'd9, 32'hAA, 1'b0, 128'd0);
      chk("hit_cnt_3", 64'(bus.hit_cnt), 64'(cnt_exp(3)));

      // Simultaneous read and write: write first, then the held read.
      @(negedge clk);
      bus.adr   = 15'd9;
      bus.wdata = 32'hCC;
      m.is_wr = 1'b1;
      m.adr   = 15'd9;
      m.wdata = 32'hCC;
      mem_q.push_back(m);
      rsp_q.push_back(32'hAA);
      rsp_q.push_back(32'hCC);
      bus.rd_req = 1'b1;
      bus.wr_req = 1'b1;
      wait_ready("both_write", 128'd0);
      bus.wr_req = 1'b0;
      wait_ready("both_read", 128'd0);
      bus.rd_req = 1'b0;
      chk("hit_cnt_4", 64'(bus.hit_cnt), 64'(cnt_exp(4)));
      chk("miss_cnt_still_1", 64'(bus.miss_cnt), 64'(cnt_exp(1)));

      // Reset during FILL abandons it; a late ack is ignored.
      @(negedge clk);
      bus.adr = 15'h20;
      m.is_wr = 1'b0;
      m.adr   = 15'h20;
      m.wdata = 32'd0;
      mem_q.push_back(m);
      bus.rd_req = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (bus.mem_rd_req === 1'b1) got = 1'b1;
      end
      chk("fill_started", 64'(got), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_fill_mem_rd_req", 64'(bus.mem_rd_req), 64'd0);
      chk("rst_fill_ready", 64'(bus.ready), 64'd0);
      chk("rst_fill_rdata", 64'(bus.rdata), 64'd0);
      chk("rst_fill_miss_cnt", 64'(bus.miss_cnt), 64'd0);
      bus.rd_req = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      bus.mem_line = line_b;
      bus.mem_ack  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_ack_ready", 64'(bus.ready), 64'd0);
         chk("late_ack_mem_rd_req", 64'(bus.mem_rd_req), 64'd0);
      end
      bus.mem_ack = 1'b0;

      // Cache invalidated: 9 misses again and fills from memory.
      cpu_read(15'd9, 32'h5002, 1'b1, line_b);
      chk("post_rst_miss_cnt", 64'(bus.miss_cnt), 64'(cnt_exp(1)));
      chk("post_rst_hit_cnt", 64'(bus.hit_cnt), 64'(cnt_exp(0)));
      cpu_read(15'd11, 32'h5004, 1'b0, 128'd0);

      repeat (3) @(negedge clk);
      chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      chk("mem_q_drained", 64'(mem_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
